// File: rtl/codec_cfg_sequencer.sv
// WM8731 codec configuration sequencer: walks a fixed register init table through an
// external I2C master with per-register NACK retry, then serves runtime single writes.
module codec_cfg_sequencer #(
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter int         WAIT_CYCLES = 1000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic        sys_clk50MHz,
  input  logic        sys_rst,
  input  logic        cfg_start,
  input  logic        usr_req,
  input  logic [15:0] usr_word,
  output logic        usr_ack,
  output logic        i2c_go,
  output logic [23:0] i2c_word,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [3:0]  cfg_index
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [3:0] LAST_IDX = 4'd10;

  typedef enum logic [3:0] {
    IDLE, LOAD, SEND, WAIT_DONE, CHECK, DELAY, READY, USR_SEND, USR_WAIT, ERROR
  } state_t;

  state_t        st;
  logic [RW-1:0] retry;
  logic [CW-1:0] cnt;
  logic          nack_q;

  function automatic logic [15:0] init_word(input logic [3:0] i);
    case (i)
      4'd0:    return 16'h1E00;
      4'd1:    return 16'h0017;
      4'd2:    return 16'h0217;
      4'd3:    return 16'h0479;
      4'd4:    return 16'h0679;
      4'd5:    return 16'h0812;
      4'd6:    return 16'h0A00;
      4'd7:    return 16'h0C00;
      4'd8:    return 16'h0E02;
      4'd9:    return 16'h1000;
      default: return 16'h1201;
    endcase
  endfunction

  always_ff @(posedge sys_clk50MHz) begin
    if (sys_rst) begin
      st        <= IDLE;
      retry     <= '0;
      cnt       <= '0;
      nack_q    <= 1'b0;
      i2c_go    <= 1'b0;
      i2c_word  <= '0;
      usr_ack   <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_index <= '0;
    end else begin
      i2c_go  <= 1'b0;
      usr_ack <= 1'b0;
      if (cfg_start && (st == IDLE || st == READY || st == ERROR)) begin
        // Full restart wins over a simultaneous runtime request.
        st        <= LOAD;
        cfg_index <= '0;
        retry     <= '0;
        cfg_busy  <= 1'b1;
        cfg_done  <= 1'b0;
        cfg_err   <= 1'b0;
      end else begin
        case (st)
          LOAD: begin
            i2c_word <= {DEV_ADDR, init_word(cfg_index)};
            i2c_go   <= 1'b1;
            st       <= SEND;
          end
          SEND: st <= WAIT_DONE;
          WAIT_DONE: if (i2c_done) begin
            nack_q <= i2c_nack;
            st     <= CHECK;
          end
          CHECK: begin
            if (nack_q) begin
              if (int'(retry) < MAX_RETRY) begin
                retry  <= retry + RW'(1);
                i2c_go <= 1'b1;
                st     <= SEND;
              end else begin
                st       <= ERROR;
                cfg_busy <= 1'b0;
                cfg_err  <= 1'b1;
              end
            end else if (cfg_index == '0) begin
              cnt <= CW'(WAIT_CYCLES);
              st  <= DELAY;
            end else if (cfg_index == LAST_IDX) begin
              st       <= READY;
              cfg_busy <= 1'b0;
              cfg_done <= 1'b1;
            end else begin
              cfg_index <= cfg_index + 4'd1;
              retry     <= '0;
              st        <= LOAD;
            end
          end
          DELAY: begin
            if (cnt == '0) begin
              cfg_index <= 4'd1;
              retry     <= '0;
              st        <= LOAD;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          // usr_req is still high in the ack cycle; skip it so one request is one write.
          READY: if (usr_req && !usr_ack) begin
            i2c_word <= {DEV_ADDR, usr_word};
            i2c_go   <= 1'b1;
            cfg_busy <= 1'b1;
            cfg_done <= 1'b0;
            st       <= USR_SEND;
          end
          USR_SEND: st <= USR_WAIT;
          USR_WAIT: if (i2c_done) begin
            usr_ack  <= 1'b1;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b1;
            if (i2c_nack) cfg_err <= 1'b1;
            st <= READY;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
